// File: rtl/mult_unit_if.sv
// Handshake bundle between the EX-stage hazard logic (master) and the
// multi-cycle HI/LO multiplier (slave).
interface mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_op, op_a, op_b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, signed_op, op_a, op_b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Shift-add MULT/MULTU unit: one WIDTH-bit ripple add plus a 1-bit right shift
// per cycle, magnitudes multiplied and the sign restored on the final edge.
module mult_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module mult_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mult_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] p;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   a_abs, b_abs, addend, sum;
  logic [WIDTH:0]     carry;
  logic [2*WIDTH-1:0] p_step;
  logic               accept, last;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (state == RUN) && (cnt == CW'(1));

  // |0x80..0| wraps to itself, which is still the right unsigned magnitude
  assign a_abs = (bus.signed_op && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign b_abs = (bus.signed_op && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

  // Ripple chain adds the multiplicand into the upper half when the LSB is set
  assign addend   = p[0] ? mcand : '0;
  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    mult_fa u_fa (
      .a  (p[WIDTH+i]),
      .b  (addend[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end

  assign p_step = {carry[WIDTH], sum, p[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are pure state decodes, so start never reaches them combinationally
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      p     <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (accept) begin
      mcand <= a_abs;
      p     <= {{WIDTH{1'b0}}, b_abs};
      neg   <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
      cnt   <= CW'(WIDTH);
    end else if (state == RUN) begin
      p   <= p_step;
      cnt <= cnt - CW'(1);
      if (last) {hi_q, lo_q} <= neg ? -p_step : p_step;
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// Randomized bench for mult_unit: a cycle-count model predicts busy/done/hi/lo
// every cycle, and directed cases pin the arithmetic to hand-computed values.
module tb_mult_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  mult_unit_if #(.WIDTH(W)) bus ();

  mult_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed({{W{a[W-1]}}, a});
      sb = $signed({{W{b[W-1]}}, b});
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Model: an accepted op keeps the unit busy for W+1 edges; the result lands
  // with done on the W-th edge and is held until the next result or reset.
  int          m_left;
  logic        m_done;
  logic [63:0] m_res, m_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (bus.start) begin
          m_res  = prod(bus.signed_op, bus.op_a, bus.op_b);
          m_left = W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 1) begin
          m_done = 1'b1;
          m_out  = m_res;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy", bus.busy, m_left != 0);
    check("done", bus.done, m_done);
    check("hi",   bus.hi,   m_out[63:32]);
    check("lo",   bus.lo,   m_out[31:0]);
  end

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!bus.busy) return;
      @(posedge clk); #2;
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic run_op(input string name, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    wait_idle();
    bus.start = 1'b1; bus.signed_op = s; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom; bus.signed_op = ~s;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      @(posedge clk); #1;
      if (bus.done) n = i;
    end
    check({name, "_latency"}, n, W);
    check({name, "_hi"}, bus.hi, eh);
    check({name, "_lo"}, bus.lo, el);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones, t1, t2, cyc;
    logic [63:0] cap;
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'h0);
    rst = 1'b0;

    run_op("u3x5",    0, 32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F);
    run_op("s-3x5",   1, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("u-3x5",   0, 32'hFFFF_FFFD, 32'd5,       32'h0000_0004, 32'hFFFF_FFF1);
    run_op("uffxff",  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("smin2",   1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("sminx1",  1, 32'h8000_0000, 32'd1,       32'hFFFF_FFFF, 32'h8000_0000);
    run_op("sax0",    1, 32'hDEAD_BEEF, 32'd0,       32'h0000_0000, 32'h0000_0000);

    // start pulsed mid-run must be ignored
    wait_idle();
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.op_a = 32'd7; bus.op_b = 32'd6;
    @(posedge clk); #2;
    bus.start = 1'b0;
    dones = 0; cap = '0;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clk); #1;
      if (i == 9)  begin bus.start = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd2; end
      if (i == 10) bus.start = 1'b0;
      if (bus.done) begin dones++; cap = {bus.hi, bus.lo}; end
    end
    check("busy_start_dones", dones, 1);
    check("busy_start_res", cap, 64'h0000_0000_0000_002A);

    // Held start: back-to-back ops, done spacing W+2
    wait_idle();
    bus.start = 1'b1; bus.op_a = 32'd7; bus.op_b = 32'd6;
    t1 = -1; t2 = -1; cyc = 0;
    for (int i = 0; i < 120 && t2 < 0; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        if (t1 < 0) t1 = cyc;
        else        t2 = cyc;
      end
    end
    check("b2b_spacing", t2 - t1, W + 2);
    #1 bus.start = 1'b0;

    // Async reset mid-operation
    wait_idle();
    bus.start = 1'b1; bus.op_a = 32'h1234; bus.op_b = 32'h5678;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_hilo", {bus.hi, bus.lo}, 64'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    run_op("after_rst", 0, 32'd9, 32'd9, 32'h0, 32'h51);

    // hi/lo hold while inputs wiggle with start low
    run_op("hold3x5", 0, 32'd3, 32'd5, 32'h0, 32'hF);
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      bus.op_a = $urandom; bus.op_b = $urandom; bus.signed_op = $urandom;
      if (bus.done) dones++;
    end
    check("hold_dones", dones, 0);
    check("hold_hilo", {bus.hi, bus.lo}, 64'hF);

    // Random traffic: starts at arbitrary times, rare async resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      bus.start     = ($urandom % 3) == 0;
      bus.signed_op = $urandom;
      bus.op_a      = pick();
      bus.op_b      = pick();
      if (($urandom % 500) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    bus.start = 1'b0;
    wait_idle();
    @(posedge clk); #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
